rle_pixel_decoder: RTL and testbench

RLE_PIXEL_DECODER -- requirements
Module: rle_pixel_decoder

---
 rtl/rle_vga_pkg.sv | 27 ++
 rtl/rle_run_slot.sv | 57 +++++
 rtl/rle_pixel_decoder.sv | 133 +++++++++++++
 tb/tb_rle_pixel_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rle_vga_pkg.sv
// Shared widths, run-word field positions and the run_word_t type used by
// the RLE pixel decoder.
package rle_vga_pkg;

   localparam int COLOUR_W  = 6;
   localparam int RUN_LEN_W = 10;
   localparam int RUN_W     = COLOUR_W + RUN_LEN_W;

   // Field positions inside the 16-bit run word from the flash reader
   localparam int COL_MSB = 15;
   localparam int COL_LSB = 10;
   localparam int LEN_MSB = 9;
   localparam int LEN_LSB = 0;

   typedef struct packed {
      logic [COLOUR_W-1:0]  colour;
      logic [RUN_LEN_W-1:0] len_m1;
   } run_word_t;

   function automatic run_word_t unpack_run(input logic [RUN_W-1:0] w);
      run_word_t r;
      r.colour = w[COL_MSB:COL_LSB];
      r.len_m1 = w[LEN_MSB:LEN_LSB];
      return r;
   endfunction

endpackage

// File: rtl/rle_run_slot.sv
// Single run register: holds colour, remaining pixel count (length-1) and a
// valid bit. Load has priority over clear, clear over decrement.
module rle_run_slot
   import rle_vga_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 load,
   input  logic [COLOUR_W-1:0]  load_col,
   input  logic [RUN_LEN_W-1:0] load_len,
   input  logic                 dec,
   output logic                 vld,
   output logic [COLOUR_W-1:0]  col,
   output logic                 last
);

   logic                 vld_q, vld_d;
   logic [COLOUR_W-1:0]  col_q, col_d;
   logic [RUN_LEN_W-1:0] rem_q, rem_d;

   // Next slot contents from load / clear / decrement requests
   always_comb begin
      vld_d = vld_q;
      col_d = col_q;
      rem_d = rem_q;
      if (load) begin
         vld_d = 1'b1;
         col_d = load_col;
         rem_d = load_len;
      end else if (clr) begin
         vld_d = 1'b0;
         col_d = '0;
         rem_d = '0;
      end else if (dec && vld_q) begin
         rem_d = rem_q - {{(RUN_LEN_W-1){1'b0}}, 1'b1};
      end
   end

   // Slot registers with synchronous reset to empty
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         col_q <= '0;
         rem_q <= '0;
      end else begin
         vld_q <= vld_d;
         col_q <= col_d;
         rem_q <= rem_d;
      end
   end

   assign vld  = vld_q;
   assign col  = col_q;
   assign last = (rem_q == '0);

endmodule

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: expands 16-bit run words into a registered 6-bit
// colour stream, one pixel per pix_en strobe, with a two-deep run buffer
// (current slot + next slot) so consecutive runs play back without a bubble.
// Optional build macro RLE_UNDERRUN_COUNT_EN adds a saturating 8-bit
// underrun_count output.
module rle_pixel_decoder
   import rle_vga_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [RUN_W-1:0]    run_data,
   input  logic                run_valid,
   output logic                run_ready,
   input  logic                pix_en,
   input  logic                frame_start,
   output logic [COLOUR_W-1:0] colour,
`ifdef RLE_UNDERRUN_COUNT_EN
   output logic [7:0]          underrun_count,
`endif
   output logic                underrun
);

   run_word_t in_run;

   logic                 cur_vld, cur_last;
   logic [COLOUR_W-1:0]  cur_col;
   logic                 cur_load, cur_clr, cur_dec;
   logic [COLOUR_W-1:0]  cur_load_col;
   logic [RUN_LEN_W-1:0] cur_load_len;

   logic                 nxt_vld_q, nxt_vld_d;
   logic [COLOUR_W-1:0]  nxt_col_q, nxt_col_d;
   logic [RUN_LEN_W-1:0] nxt_len_q, nxt_len_d;

   logic                 move, accept, direct, consume_last, underrun_pix;
   logic [COLOUR_W-1:0]  colour_q, colour_d;
   logic                 underrun_q, underrun_d;

   assign in_run = unpack_run(run_data);

   rle_run_slot u_cur_slot (
      .clk      (clk),
      .rst      (rst),
      .clr      (cur_clr),
      .load     (cur_load),
      .load_col (cur_load_col),
      .load_len (cur_load_len),
      .dec      (cur_dec),
      .vld      (cur_vld),
      .col      (cur_col),
      .last     (cur_last)
   );

   // Handshake, slot movement, and next-state for next slot / colour / underrun.
   // An empty current slot is refilled from the next slot on any cycle so a
   // late word never gets stuck behind continuous pix_en strobes.
   always_comb begin
      consume_last = cur_vld && pix_en && cur_last;
      move         = !frame_start && nxt_vld_q && (!cur_vld || consume_last);
      run_ready    = !rst && !frame_start && (!nxt_vld_q || move);
      accept       = run_valid && run_ready;
      direct       = !cur_vld && !nxt_vld_q && !pix_en;
      underrun_pix = pix_en && !cur_vld && !frame_start;

      cur_load     = move || (accept && direct);
      cur_load_col = move ? nxt_col_q : in_run.colour;
      cur_load_len = move ? nxt_len_q : in_run.len_m1;
      cur_clr      = frame_start || (consume_last && !nxt_vld_q);
      cur_dec      = cur_vld && pix_en && !cur_last && !frame_start;

      nxt_vld_d = nxt_vld_q;
      nxt_col_d = nxt_col_q;
      nxt_len_d = nxt_len_q;
      if (frame_start) begin
         nxt_vld_d = 1'b0;
      end else if (accept && !direct) begin
         nxt_vld_d = 1'b1;
         nxt_col_d = in_run.colour;
         nxt_len_d = in_run.len_m1;
      end else if (move) begin
         nxt_vld_d = 1'b0;
      end

      colour_d   = (pix_en && cur_vld && !frame_start) ? cur_col : '0;
      underrun_d = frame_start ? 1'b0 : (underrun_q || underrun_pix);
   end

   // Next slot, output colour and sticky underrun registers
   always_ff @(posedge clk) begin
      if (rst) begin
         nxt_vld_q  <= 1'b0;
         nxt_col_q  <= '0;
         nxt_len_q  <= '0;
         colour_q   <= '0;
         underrun_q <= 1'b0;
      end else begin
         nxt_vld_q  <= nxt_vld_d;
         nxt_col_q  <= nxt_col_d;
         nxt_len_q  <= nxt_len_d;
         colour_q   <= colour_d;
         underrun_q <= underrun_d;
      end
   end

   assign colour   = colour_q;
   assign underrun = underrun_q;

`ifdef RLE_UNDERRUN_COUNT_EN
   logic [7:0] ucnt_q, ucnt_d;

   // Saturating count of starved pixels, cleared at each frame start
   always_comb begin
      ucnt_d = ucnt_q;
      if (frame_start) begin
         ucnt_d = '0;
      end else if (underrun_pix && (ucnt_q != 8'hFF)) begin
         ucnt_d = ucnt_q + 8'd1;
      end
   end

   // Underrun counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Scoreboard bench for rle_pixel_decoder: accepted runs are expanded into a
// pixel queue, each driven cycle pushes its expected colour, and the value is
// popped and compared one cycle later.
module tb_rle_pixel_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] run_data;
   logic        run_valid;
   logic        run_ready;
   logic        pix_en;
   logic        frame_start;
   logic [5:0]  colour;
   logic        underrun;
`ifdef RLE_UNDERRUN_COUNT_EN
   logic [7:0]  underrun_count;
`endif

   int n_chk = 0;
   int n_bad = 0;

   logic [5:0] pix_q[$];   // pixels the decoder still owes
   logic [5:0] exp_q[$];   // expected colour per driven cycle
   logic       exp_ur;

   always #5 clk = ~clk;

   rle_pixel_decoder dut (
      .clk            (clk),
      .rst            (rst),
      .run_data       (run_data),
      .run_valid      (run_valid),
      .run_ready      (run_ready),
      .pix_en         (pix_en),
      .frame_start    (frame_start),
      .colour         (colour),
`ifdef RLE_UNDERRUN_COUNT_EN
      .underrun_count (underrun_count),
`endif
      .underrun       (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] word(input logic [5:0] c, input logic [9:0] l);
      return {c, l};
   endfunction

   // One clock of stimulus; called at posedge+1, returns whether the word was taken
   task automatic cyc(input logic v, input logic [15:0] d, input logic p,
                      input logic fs, output logic acc);
      logic [5:0] e;
      run_valid   = v;
      run_data    = d;
      pix_en      = p;
      frame_start = fs;
      #1;
      acc = v && run_ready;
      if (fs) chk("ready_in_frame_start", run_ready, 0);
      e = 6'h00;
      if (fs) begin
         pix_q.delete();
         exp_ur = 1'b0;
      end else if (p) begin
         if (pix_q.size() > 0) e = pix_q.pop_front();
         else exp_ur = 1'b1;
      end
      if (acc && !fs) begin
         for (int i = 0; i <= int'(d[9:0]); i++) pix_q.push_back(d[15:10]);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk("colour", colour, exp_q.pop_front());
      chk("underrun", underrun, exp_ur);
   endtask

   task automatic idle(input int n, input logic p);
      logic a;
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, p, 1'b0, a);
   endtask

   task automatic fstart();
      logic a;
      cyc(1'b0, 16'h0000, 1'b0, 1'b1, a);
   endtask

   initial begin
      logic acc;
      rst = 1'b1; run_valid = 1'b0; run_data = '0; pix_en = 1'b0; frame_start = 1'b0;
      exp_ur = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", run_ready, 0);
      chk("rst_colour", colour, 0);
      chk("rst_underrun", underrun, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", run_ready, 1);

      // two runs back to back, pix_en every cycle, then starvation
      cyc(1'b1, word(6'h30, 10'd2), 1'b0, 1'b0, acc); chk("acc_w30", acc, 1);
      cyc(1'b1, word(6'h0C, 10'd0), 1'b0, 1'b0, acc); chk("acc_w0c", acc, 1);
      idle(5, 1'b1);
      fstart();

      // backpressure with pix_en held low
      cyc(1'b1, word(6'h03, 10'd0), 1'b0, 1'b0, acc); chk("bp_acc1", acc, 1);
      cyc(1'b1, word(6'h3C, 10'd1), 1'b0, 1'b0, acc); chk("bp_acc2", acc, 1);
      cyc(1'b1, word(6'h2A, 10'd0), 1'b0, 1'b0, acc); chk("bp_stall1", acc, 0);
      cyc(1'b1, word(6'h2A, 10'd0), 1'b0, 1'b0, acc); chk("bp_stall2", acc, 0);
      cyc(1'b1, word(6'h2A, 10'd0), 1'b1, 1'b0, acc); chk("bp_acc3", acc, 1);
      idle(4, 1'b1);
      fstart();

      // maximum run length 1024
      cyc(1'b1, word(6'h15, 10'h3FF), 1'b0, 1'b0, acc); chk("long_acc", acc, 1);
      cyc(1'b1, word(6'h2A, 10'd0), 1'b0, 1'b0, acc);   chk("long_acc2", acc, 1);
      idle(1024, 1'b1);
      chk("long_not_starved", underrun, 0);
      idle(2, 1'b1);
      fstart();

      // frame_start mid-run with a word offered and pix_en high
      idle(1, 1'b1);
      chk("ur_set_before_fs", underrun, 1);
      cyc(1'b1, word(6'h3F, 10'd5), 1'b0, 1'b0, acc);
      cyc(1'b1, word(6'h01, 10'd3), 1'b0, 1'b0, acc);
      idle(2, 1'b1);
      cyc(1'b1, word(6'h22, 10'd0), 1'b1, 1'b1, acc); chk("fs_no_accept", acc, 0);
      idle(1, 1'b1);
      fstart();

      // synchronous reset mid-run
      cyc(1'b1, word(6'h11, 10'd9), 1'b0, 1'b0, acc);
      idle(3, 1'b1);
      rst = 1'b1; run_valid = 1'b1; run_data = word(6'h07, 10'd0); pix_en = 1'b1;
      #1;
      chk("rst_mid_ready", run_ready, 0);
      @(posedge clk);
      #1;
      chk("rst_mid_colour", colour, 0);
      chk("rst_mid_underrun", underrun, 0);
      pix_q.delete(); exp_ur = 1'b0;
      rst = 1'b0;
      cyc(1'b1, word(6'h2B, 10'd1), 1'b0, 1'b0, acc); chk("post_rst_acc", acc, 1);
      idle(3, 1'b1);
      fstart();

      // random run pairs played back with gappy pix_en
      for (int k = 0; k < 8; k++) begin
         int guard;
         cyc(1'b1, word(6'($urandom), 10'($urandom_range(0, 20))), 1'b0, 1'b0, acc);
         cyc(1'b1, word(6'($urandom), 10'($urandom_range(0, 20))), 1'b0, 1'b0, acc);
         guard = 0;
         while (pix_q.size() > 0 && guard < 500) begin
            cyc(1'b0, 16'h0000, 1'($urandom_range(0, 1)), 1'b0, acc);
            guard++;
         end
         chk("rand_drained", pix_q.size(), 0);
         fstart();
      end

`ifdef RLE_UNDERRUN_COUNT_EN
      idle(300, 1'b1);
      chk("ucnt_sat", underrun_count, 8'd255);
      fstart();
      chk("ucnt_clr", underrun_count, 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
